// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults and FSM state encoding for the UART/ALU bridge
package uart_pkg;
    localparam int DBIT_DEF = 8;
    localparam int NB_OP_DEF = 6;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_GET_A = 3'd1;
    localparam logic [2:0] ST_GET_B = 3'd2;
    localparam logic [2:0] ST_GET_OP = 3'd3;
    localparam logic [2:0] ST_CALC = 3'd4;
    localparam logic [2:0] ST_SEND = 3'd5;
    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        GET_A = ST_GET_A,
        GET_B = ST_GET_B,
        GET_OP = ST_GET_OP,
        CALC = ST_CALC,
        SEND = ST_SEND
    } state_t;
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: saturating baud-tick counter flagging an inter-byte timeout
module uart_timeout_cnt #(
    parameter int TO_TICKS = 4096
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_clear,
    output logic o_expired
);
    localparam int W = $clog2(TO_TICKS + 1);
    logic [W-1:0] cnt;
    assign o_expired = cnt == W'(TO_TICKS);
    always_ff @(posedge clock)
        if (i_reset || i_clear) cnt <= '0;
        else if (i_tick && !o_expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: RX bytes A,B,op -> ALU -> TX result; timeout with UART_ALU_TIMEOUT_EN
module uart_alu_interface
    import uart_pkg::*;
#(
    parameter int DBIT = DBIT_DEF,
    parameter int NB_OP = NB_OP_DEF,
    parameter int TO_TICKS = 4096
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_rx_empty,
    input  logic [DBIT-1:0]  i_rx_data,
    output logic             o_rx_rd,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_op,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_full,
    output logic             o_tx_wr,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_timeout
);
    state_t state;
    logic expired;
    assign o_rx_rd = !i_reset && !i_rx_empty && (state inside {GET_A, GET_B, GET_OP});
    assign o_tx_wr = !i_reset && !i_tx_full && state == SEND;
`ifdef UART_ALU_TIMEOUT_EN
    logic to_win;
    assign to_win = state inside {GET_B, GET_OP};
    uart_timeout_cnt #(.TO_TICKS(TO_TICKS)) u_timeout (
        .clock(clock),
        .i_reset(i_reset),
        .i_tick(i_tick && to_win),
        .i_clear(!to_win || o_rx_rd),
        .o_expired(expired)
    );
`else
    localparam int unused_to_ticks = TO_TICKS;
    logic unused_tick;
    assign unused_tick = i_tick;
    assign expired = 1'b0;
`endif
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state <= IDLE;
            o_data_a <= '0;
            o_data_b <= '0;
            o_op <= '0;
            o_tx_data <= '0;
            o_busy <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_busy <= 1'b1;
            o_timeout <= 1'b0;
            case (state)
                IDLE: state <= GET_A;
                GET_A: if (!i_rx_empty) begin
                    o_data_a <= i_rx_data;
                    state <= GET_B;
                end
                GET_B: if (!i_rx_empty) begin
                    o_data_b <= i_rx_data;
                    state <= GET_OP;
                end else if (expired) begin
                    state <= GET_A;
                    o_timeout <= 1'b1;
                end
                GET_OP: if (!i_rx_empty) begin
                    o_op <= i_rx_data[NB_OP-1:0];
                    state <= CALC;
                end else if (expired) begin
                    state <= GET_A;
                    o_timeout <= 1'b1;
                end
                CALC: begin
                    o_tx_data <= i_alu_result;
                    state <= SEND;
                end
                SEND: if (!i_tx_full) state <= GET_A;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
